lut7_cfg_ctrl: RTL and testbench
================================

LUT7_CFG_CTRL -- requirements
Module: lut7_cfg_ctrl

Interface
REQ-001 The block SHALL have parameter INIT, default 128'h0: reset contents of the active 128-entry table.
REQ-002 The block SHALL have parameter LOC, default "UNPLACED": placement tag, no functional effect.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL update on the rising CLK edge.
REQ-004 CLK  in  1  clock.
REQ-005 RST  in  1  synchronous active-high reset.
REQ-006 CFG_START  in  1  request to begin a table load.
REQ-007 CFG_ABORT  in  1  cancel a load in progress.
REQ-008 CFG_VALID  in  1  CFG_DATA holds a valid word.
REQ-009 CFG_DATA  in  32  table word; word k carries entries 32k+31..32k.
REQ-010 CFG_READY  out  1  block accepts a word this cycle.
REQ-011 CFG_BUSY  out  1  load in progress.
REQ-012 CFG_DONE  out  1  one-cycle pulse on commit.
REQ-013 ADR  in  7  lookup address.
REQ-014 O  out  1  lookup result, combinational: active[ADR].

Function
REQ-015 The FSM SHALL have states IDLE, FILL and COMMIT.
REQ-016 IDLE: CFG_READY=0, CFG_BUSY=0; CFG_START=1 -> FILL, word counter cleared to 0.
REQ-017 FILL: CFG_READY=1, CFG_BUSY=1; each cycle with CFG_VALID&CFG_READY SHALL write CFG_DATA to shadow word [counter] and increment the 2-bit counter.
REQ-018 FILL: acceptance of word 3 SHALL move to COMMIT; the counter wraps to 0.
REQ-019 COMMIT lasts exactly one cycle: CFG_READY=0, CFG_BUSY=1, CFG_DONE=1; active <= shadow at the end of the cycle; next state IDLE.
REQ-020 O SHALL reflect the new table from the first cycle after COMMIT; with back-to-back words, START at cycle 0 -> words at cycles 1-4 -> COMMIT cycle 5 -> new O cycle 6.
REQ-021 CFG_VALID gaps in FILL SHALL stall without losing progress.
REQ-022 CFG_ABORT in FILL SHALL return to IDLE next cycle, discard the shadow, and leave the active table unchanged; it takes priority over a simultaneous CFG_VALID (that word is not written).
REQ-023 CFG_ABORT in IDLE or COMMIT SHALL be ignored; a commit is never cancelled.
REQ-024 CFG_START outside IDLE SHALL be ignored.
REQ-025 O SHALL never show partially loaded data; the active table changes only in COMMIT.

Reset
REQ-026 RST SHALL force state IDLE, counter 0, shadow 0, active = INIT, CFG_READY=0, CFG_BUSY=0, CFG_DONE=0.
REQ-027 RST during FILL or COMMIT SHALL take priority; no commit occurs.

Configuration
REQ-028 With LUT7_CFG_READBACK_EN defined, ports RB_SEL (in, 2) and RB_DATA (out, 32) SHALL exist; RB_DATA registers active word RB_SEL with 1-cycle latency and resets to 0.
REQ-029 Without LUT7_CFG_READBACK_EN, those ports and their logic SHALL be absent; all other behaviour is identical.

Structure
REQ-030 Package lut7_cfg_pkg SHALL hold the state enum, WORD_W=32, NUM_WORDS=4 and TABLE_DEPTH=128.
REQ-031 Sub-module lut7_cfg_table SHALL hold the shadow and active registers, the commit swap and the O lookup mux; lut7_cfg_ctrl holds the FSM, counter and handshake.

Verification
REQ-032 After reset with INIT=128'h8000_0000_0000_0000_0000_0000_0000_0001: ADR=0 -> O=1; ADR=127 -> O=1; ADR=64 -> O=0.
REQ-033 START, then words 32'hFFFFFFFF, 0, 0, 32'h1 back-to-back: CFG_DONE pulses at cycle 5; from cycle 6, ADR=31 -> O=1, ADR=32 -> O=0, ADR=96 -> O=1.
REQ-034 START, 2 words, then ABORT together with CFG_VALID: IDLE the next cycle, no CFG_DONE, O unchanged for all 128 addresses.
REQ-035 Words with VALID gaps of 0, 3 and 1 cycles: table committed correctly; CFG_READY stays 1 throughout FILL.
REQ-036 RST asserted after word 3 of 4: the active table equals INIT and a following full load succeeds.
REQ-037 With LUT7_CFG_READBACK_EN defined, after the REQ-033 load: RB_SEL=3 -> RB_DATA=32'h1 one cycle later.

Source files
------------

// File: rtl/lut7_cfg_pkg.sv
// Shared types and sizing for the 128-entry reconfigurable LUT7 controller.
// Optional readback port is enabled by defining LUT7_CFG_READBACK_EN.
package lut7_cfg_pkg;

  localparam int WORD_W      = 32;
  localparam int NUM_WORDS   = 4;
  localparam int TABLE_DEPTH = 128;
  localparam int CNT_W       = $clog2(NUM_WORDS);
  localparam int ADR_W       = $clog2(TABLE_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

endpackage

// File: rtl/lut7_cfg_table.sv
// Shadow/active table storage with atomic commit and combinational lookup.
// Readback register present only when LUT7_CFG_READBACK_EN is defined.
module lut7_cfg_table
  import lut7_cfg_pkg::*;
#(
  parameter logic [TABLE_DEPTH-1:0] INIT = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [CNT_W-1:0]  wr_idx,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              discard,
  input  logic              commit,
  input  logic [ADR_W-1:0]  adr,
  output logic              o
`ifdef LUT7_CFG_READBACK_EN
  ,
  input  logic [CNT_W-1:0]  rb_sel,
  output logic [WORD_W-1:0] rb_data
`endif
);

  logic [WORD_W-1:0]      shadow_reg [NUM_WORDS];
  logic [TABLE_DEPTH-1:0] shadow_flat;
  logic [TABLE_DEPTH-1:0] active_reg;

  // An aborted load clears the shadow so no stale words survive into the next load.
  generate
    for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_word
      always_ff @(posedge clk) begin
        if (rst || discard) begin
          shadow_reg[gi] <= '0;
        end else if (wr_en && (wr_idx == CNT_W'(gi))) begin
          shadow_reg[gi] <= wr_data;
        end
      end
      assign shadow_flat[gi*WORD_W +: WORD_W] = shadow_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      active_reg <= INIT;
    end else if (commit) begin
      active_reg <= shadow_flat;
    end
  end

  assign o = active_reg[adr];

`ifdef LUT7_CFG_READBACK_EN
  logic [WORD_W-1:0] rb_data_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      rb_data_reg <= '0;
    end else begin
      rb_data_reg <= active_reg[rb_sel*WORD_W +: WORD_W];
    end
  end

  assign rb_data = rb_data_reg;
`endif

endmodule

// File: rtl/lut7_cfg_ctrl.sv
// LUT7 configuration controller: IDLE/FILL/COMMIT load FSM driving lut7_cfg_table.
// Define LUT7_CFG_READBACK_EN to add the rb_sel/rb_data readback port.
module lut7_cfg_ctrl
  import lut7_cfg_pkg::*;
#(
  parameter logic [TABLE_DEPTH-1:0] INIT = '0,
  parameter                         LOC  = "UNPLACED"
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_start,
  input  logic              cfg_abort,
  input  logic              cfg_valid,
  input  logic [WORD_W-1:0] cfg_data,
  output logic              cfg_ready,
  output logic              cfg_busy,
  output logic              cfg_done,
  input  logic [ADR_W-1:0]  adr,
  output logic              o
`ifdef LUT7_CFG_READBACK_EN
  ,
  input  logic [CNT_W-1:0]  rb_sel,
  output logic [WORD_W-1:0] rb_data
`endif
);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             wr_en, discard, commit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    cfg_ready  = 1'b0;
    cfg_busy   = 1'b0;
    cfg_done   = 1'b0;
    wr_en      = 1'b0;
    discard    = 1'b0;
    commit     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (cfg_start) begin
          state_next = ST_FILL;
          cnt_next   = '0;
        end
      end
      ST_FILL: begin
        cfg_ready = 1'b1;
        cfg_busy  = 1'b1;
        // Abort wins over a word offered in the same cycle.
        if (cfg_abort) begin
          state_next = ST_IDLE;
          discard    = 1'b1;
        end else if (cfg_valid) begin
          wr_en    = 1'b1;
          cnt_next = cnt_reg + CNT_W'(1);
          if (cnt_reg == CNT_W'(NUM_WORDS - 1)) begin
            state_next = ST_COMMIT;
          end
        end
      end
      ST_COMMIT: begin
        cfg_busy   = 1'b1;
        cfg_done   = 1'b1;
        commit     = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  lut7_cfg_table #(
    .INIT (INIT)
  ) u_table (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_idx  (cnt_reg),
    .wr_data (cfg_data),
    .discard (discard),
    .commit  (commit),
    .adr     (adr),
    .o       (o)
`ifdef LUT7_CFG_READBACK_EN
    ,
    .rb_sel  (rb_sel),
    .rb_data (rb_data)
`endif
  );

endmodule

// File: tb/tb_lut7_cfg_ctrl.sv
// Scoreboard bench for lut7_cfg_ctrl: per-cycle expectations from a table-level
// reference model are queued by the stimulus and checked by a negedge monitor.
module tb_lut7_cfg_ctrl;

  localparam logic [127:0] INIT_V = 128'h8000_0000_0000_0000_0000_0000_0000_0001;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_start = 1'b0, cfg_abort = 1'b0, cfg_valid = 1'b0;
  logic [31:0] cfg_data = '0;
  logic        cfg_ready, cfg_busy, cfg_done, o;
  logic [6:0]  adr = '0;
  logic [1:0]  rb_sel = '0;
`ifdef LUT7_CFG_READBACK_EN
  logic [31:0] rb_data;
`endif

  lut7_cfg_ctrl #(.INIT(INIT_V), .LOC("TB")) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_start (cfg_start),
    .cfg_abort (cfg_abort),
    .cfg_valid (cfg_valid),
    .cfg_data  (cfg_data),
    .cfg_ready (cfg_ready),
    .cfg_busy  (cfg_busy),
    .cfg_done  (cfg_done),
    .adr       (adr),
    .o         (o)
`ifdef LUT7_CFG_READBACK_EN
    ,
    .rb_sel    (rb_sel),
    .rb_data   (rb_data)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        ready;
    logic        busy;
    logic        done;
    logic        o;
    logic [31:0] rb;
    logic [6:0]  adr;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: what the table holds and where a load stands.
  logic [127:0] m_active;
  logic [31:0]  m_words[4];
  bit           m_loading;
  bit           m_commit_due;
  int           m_got;
  logic [31:0]  m_rb;

  task automatic model_reset();
    m_active     = INIT_V;
    m_loading    = 1'b0;
    m_commit_due = 1'b0;
    m_got        = 0;
    m_rb         = '0;
    for (int i = 0; i < 4; i++) m_words[i] = '0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s cycle=%0d adr=%0d actual=%h required=%h", name, cyc, adr, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("cfg_ready", {31'd0, cfg_ready}, {31'd0, e.ready});
      check("cfg_busy",  {31'd0, cfg_busy},  {31'd0, e.busy});
      check("cfg_done",  {31'd0, cfg_done},  {31'd0, e.done});
      check("o",         {31'd0, o},         {31'd0, e.o});
`ifdef LUT7_CFG_READBACK_EN
      check("rb_data", rb_data, e.rb);
`endif
      if (e.done) $display("[TB] commit observed at cycle %0d", cyc);
    end
  end

  // One clock of stimulus: queue what this cycle must show, then advance the model.
  task automatic drive(input bit r, input bit st, input bit ab, input bit v,
                       input logic [31:0] d, input logic [6:0] a, input logic [1:0] sel);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; cfg_start = st; cfg_abort = ab; cfg_valid = v;
    cfg_data = d; adr = a; rb_sel = sel;
    e.ready = m_loading;
    e.busy  = m_loading || m_commit_due;
    e.done  = m_commit_due;
    e.o     = m_active[a];
    e.rb    = m_rb;
    e.adr   = a;
    exp_q.push_back(e);
    if (r) begin
      model_reset();
    end else begin
      m_rb = m_active[sel*32 +: 32];
      if (m_commit_due) begin
        m_active     = {m_words[3], m_words[2], m_words[1], m_words[0]};
        m_commit_due = 1'b0;
      end else if (m_loading) begin
        if (ab) begin
          m_loading = 1'b0;
          for (int i = 0; i < 4; i++) m_words[i] = '0;
        end else if (v) begin
          m_words[m_got] = d;
          m_got++;
          if (m_got == 4) begin
            m_loading    = 1'b0;
            m_commit_due = 1'b1;
            m_got        = 0;
          end
        end
      end else if (st) begin
        m_loading = 1'b1;
        m_got     = 0;
      end
    end
  endtask

  task automatic idle(input logic [6:0] a, input logic [1:0] sel);
    drive(0, 0, 0, 0, $urandom, a, sel);
  endtask

  task automatic word(input logic [31:0] d);
    drive(0, 0, 0, 1, d, 7'($urandom_range(0, 127)), 2'($urandom_range(0, 3)));
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);

    // Reset contents visible through lookup.
    drive(1, 0, 0, 0, 0, 7'd0, 2'd0);
    idle(7'd0, 2'd0);
    idle(7'd127, 2'd3);
    idle(7'd64, 2'd0);

    // Back-to-back load, then targeted lookups and readback of word 3.
    drive(0, 1, 0, 0, 0, 7'd0, 2'd0);
    word(32'hFFFF_FFFF); word(32'h0); word(32'h0); word(32'h1);
    idle(7'd0, 2'd0);
    idle(7'd31, 2'd3);
    idle(7'd32, 2'd3);
    idle(7'd96, 2'd0);

    // Abort together with a valid word after two words; whole table unchanged.
    drive(0, 1, 0, 0, 0, 7'd0, 2'd0);
    word(32'hAAAA_5555); word(32'h1234_5678);
    drive(0, 0, 1, 1, 32'hDEAD_BEEF, 7'd0, 2'd0);
    for (int a = 0; a < 128; a++) idle(7'(a), 2'(a));

    // Valid gaps of 0, 3 and 1 cycles.
    drive(0, 1, 0, 0, 0, 7'd5, 2'd0);
    word(32'h0F0F_0F0F); word(32'hCAFE_F00D);
    repeat (3) idle(7'd40, 2'd1);
    word(32'h8000_0001);
    idle(7'd64, 2'd2);
    word(32'h7654_3210);
    for (int a = 0; a < 128; a += 9) idle(7'(a), 2'(a));

    // Reset after word 3 of 4, then a full load.
    drive(0, 1, 0, 0, 0, 7'd0, 2'd0);
    word(32'h1111_1111); word(32'h2222_2222); word(32'h3333_3333);
    drive(1, 0, 0, 1, 32'h4444_4444, 7'd0, 2'd0);
    for (int a = 0; a < 128; a += 7) idle(7'(a), 2'(a));
    idle(7'd127, 2'd3);
    drive(0, 1, 0, 0, 0, 7'd0, 2'd0);
    word(32'h0000_FFFF); word(32'hFFFF_0000); word(32'h5A5A_5A5A); word(32'hA5A5_A5A5);
    for (int a = 0; a < 128; a += 11) idle(7'(a), 2'(a));

    // Randomized traffic, including ignored start/abort and occasional reset.
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 79) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 15) == 0), ($urandom_range(0, 2) != 0),
            $urandom, 7'($urandom_range(0, 127)), 2'($urandom_range(0, 3)));
    end
    idle(7'd0, 2'd0);
    idle(7'd0, 2'd0);

    @(negedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
